// File: rtl/sd_cmd_ctrl_if.sv
// Host-side command bus and CMD-pad signals of the SD command sequencer.
// The sequencer takes the slave view; the host and pad side take the master view.
interface sd_cmd_ctrl_if;
    logic         cmd_start;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   resp_type;
    logic         pad_output_input;
    logic         pad_enable;
    logic         pad_data_in;
    logic         pad_data_out;
    logic         busy;
    logic         done;
    logic [135:0] resp_data;
    logic         timeout_err;
    logic         crc_err;

    modport master (
        output cmd_start, cmd_index, cmd_arg, resp_type, pad_data_out,
        input  pad_output_input, pad_enable, pad_data_in,
        input  busy, done, resp_data, timeout_err, crc_err
    );

    modport slave (
        input  cmd_start, cmd_index, cmd_arg, resp_type, pad_data_out,
        output pad_output_input, pad_enable, pad_data_in,
        output busy, done, resp_data, timeout_err, crc_err
    );
endinterface

// File: rtl/sd_cmd_ctrl.sv
// SD CMD-line sequencer: sends a CRC7-protected 48-bit command, then receives a 48/136-bit response.
// Optional response CRC checker enabled by defining SD_CMD_RESP_CRC_CHECK_EN.
module sd_cmd_ctrl #(
    parameter int TIMEOUT  = 64,
    parameter int TURN_CYC = 2
) (
    input logic          sd_clock,
    input logic          reset_n,
    sd_cmd_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        TURN,
        WAIT_START,
        RECV,
        DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [39:0]         tx_shift;
    logic [6:0]          tx_crc;
    logic [5:0]          bit_cnt;
    logic                has_resp;
    logic                long_resp;
    logic [TURN_W-1:0]   turn_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [7:0]          rx_cnt;
    logic [135:0]        resp_q;
    logic                timeout_q;
    logic                tx_bit;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_ff @(posedge sd_clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Bits 47..8 come from the payload shifter, 7..1 from the CRC register, 0 is the end bit.
    always_comb begin
        next_state           = state;
        tx_bit               = 1'b1;
        bus.pad_output_input = 1'b0;
        bus.pad_data_in      = 1'b1;
        if (bit_cnt >= 6'd8)       tx_bit = tx_shift[39];
        else if (bit_cnt != 6'd0)  tx_bit = tx_crc[6];
        case (state)
            IDLE: begin
                if (bus.cmd_start) next_state = SEND;
            end
            SEND: begin
                bus.pad_output_input = 1'b1;
                bus.pad_data_in      = tx_bit;
                if (bit_cnt == 6'd0) next_state = has_resp ? TURN : DONE;
            end
            TURN: begin
                if (turn_cnt == TURN_LAST) next_state = WAIT_START;
            end
            WAIT_START: begin
                if (!bus.pad_data_out)          next_state = RECV;
                else if (wait_cnt == WAIT_LAST) next_state = DONE;
            end
            RECV: begin
                if (rx_cnt == 8'd0) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign bus.busy        = (state != IDLE);
    assign bus.pad_enable  = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.resp_data   = resp_q;
    assign bus.timeout_err = timeout_q;

    always_ff @(posedge sd_clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_shift  <= '0;
            tx_crc    <= '0;
            bit_cnt   <= '0;
            has_resp  <= 1'b0;
            long_resp <= 1'b0;
            turn_cnt  <= '0;
            wait_cnt  <= '0;
            rx_cnt    <= '0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_start) begin
                        tx_shift  <= {2'b01, bus.cmd_index, bus.cmd_arg};
                        tx_crc    <= '0;
                        bit_cnt   <= 6'd47;
                        has_resp  <= (bus.resp_type == 2'b01) || (bus.resp_type == 2'b10);
                        long_resp <= (bus.resp_type == 2'b10);
                        resp_q    <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                SEND: begin
                    bit_cnt  <= bit_cnt - 6'd1;
                    turn_cnt <= '0;
                    if (bit_cnt >= 6'd8) begin
                        tx_shift <= {tx_shift[38:0], 1'b0};
                        tx_crc   <= crc7_step(tx_crc, tx_shift[39]);
                    end else begin
                        tx_crc   <= {tx_crc[5:0], 1'b0};
                    end
                end
                TURN: begin
                    turn_cnt <= turn_cnt + TURN_W'(1);
                    wait_cnt <= '0;
                end
                WAIT_START: begin
                    // The start bit becomes the response MSB; the counter stops at its last value.
                    if (!bus.pad_data_out) begin
                        resp_q <= {resp_q[134:0], 1'b0};
                        rx_cnt <= long_resp ? 8'd134 : 8'd46;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                RECV: begin
                    resp_q <= {resp_q[134:0], bus.pad_data_out};
                    rx_cnt <= rx_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef SD_CMD_RESP_CRC_CHECK_EN
    logic [6:0] rx_crc;
    logic       crc_q;
    logic       crc_window;

    // rx_cnt equals the index of the bit arriving this cycle; the start bit adds nothing to a zero CRC.
    assign crc_window = (rx_cnt >= 8'd8) && (rx_cnt <= (long_resp ? 8'd127 : 8'd47));

    always_ff @(posedge sd_clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_crc <= '0;
            crc_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_start) begin
                        rx_crc <= '0;
                        crc_q  <= 1'b0;
                    end
                end
                RECV: begin
                    if (crc_window) rx_crc <= crc7_step(rx_crc, bus.pad_data_out);
                    if (rx_cnt == 8'd0) crc_q <= (rx_crc != resp_q[6:0]);
                end
                default: ;
            endcase
        end
    end

    assign bus.crc_err = crc_q;
`else
    assign bus.crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed and randomized bench for sd_cmd_ctrl with a polynomial-division reference model.
// Honours SD_CMD_RESP_CRC_CHECK_EN when predicting crc_err.
module tb_sd_cmd_ctrl;
    localparam int TIMEOUT  = 64;
    localparam int TURN_CYC = 2;

    logic sd_clock = 1'b0;
    logic reset_n  = 1'b0;

    sd_cmd_ctrl_if bus();

    sd_cmd_ctrl #(.TIMEOUT(TIMEOUT), .TURN_CYC(TURN_CYC)) dut (
        .sd_clock (sd_clock),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 sd_clock = ~sd_clock;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [47:0]  sent_frame;
    logic [47:0]  exp_frame;
    logic         sent_oe_ok;
    logic [135:0] resp;
    logic [127:0] rnd;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rt;
    int           cnt;
    int           gap;

    // Remainder of msg * x^7 divided by x^7 + x^3 + 1, msg right-justified with len bits.
    function automatic logic [6:0] crc_div(input logic [127:0] msg, input int len);
        logic [134:0] r;
        r = {msg, 7'b0};
        for (int i = len + 6; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [5:0] i, input logic [31:0] a);
        logic [39:0] m;
        m = {2'b01, i, a};
        return {m, crc_div({88'b0, m}, 40), 1'b1};
    endfunction

    function automatic logic exp_crc_err(input logic [135:0] r, input logic [1:0] t);
`ifdef SD_CMD_RESP_CRC_CHECK_EN
        if (t == 2'b01) return crc_div({88'b0, r[47:8]}, 40) != r[7:1];
        if (t == 2'b10) return crc_div({8'b0, r[127:8]}, 120) != r[7:1];
        return 1'b0;
`else
        return (r[0] & t[0] & t[1] & 1'b0);
`endif
    endfunction

    task checkOutput(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues a command from a falling edge and records the 48 bits driven during SEND.
    task applyStimulus(input logic [5:0] i_idx, input logic [31:0] i_arg,
                       input logic [1:0] i_rt, input int poke_at);
        bus.cmd_index = i_idx;
        bus.cmd_arg   = i_arg;
        bus.resp_type = i_rt;
        bus.cmd_start = 1'b1;
        @(negedge sd_clock);
        sent_frame = '0;
        sent_oe_ok = 1'b1;
        for (int i = 0; i < 48; i++) begin
            bus.cmd_start = (i == poke_at);
            sent_frame = {sent_frame[46:0], bus.pad_data_in};
            if (bus.pad_output_input !== 1'b1 || bus.pad_enable !== 1'b1 || bus.busy !== 1'b1)
                sent_oe_ok = 1'b0;
            @(negedge sd_clock);
        end
        bus.cmd_start = 1'b0;
        checkOutput("frame", 136'(sent_frame), 136'(cmd_frame(i_idx, i_arg)));
        checkOutput("send_pad_dir", 136'(sent_oe_ok), 136'(1));
    endtask

    task driveResponse(input logic [135:0] bits, input int nbits, input int i_gap);
        checkOutput("turn_released", 136'({bus.pad_output_input, bus.pad_data_in}), 136'(2'b01));
        bus.pad_data_out = 1'b1;
        repeat (TURN_CYC + i_gap) @(negedge sd_clock);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.pad_data_out = bits[i];
            @(negedge sd_clock);
        end
        bus.pad_data_out = 1'b1;
    endtask

    task checkDone(input logic [135:0] er, input logic eto, input logic ece);
        checkOutput("done_pulse", 136'({bus.done, bus.busy}), 136'(2'b11));
        checkOutput("resp_data", bus.resp_data, er);
        checkOutput("timeout_err", 136'(bus.timeout_err), 136'(eto));
        checkOutput("crc_err", 136'(bus.crc_err), 136'(ece));
        @(negedge sd_clock);
        bus.cmd_start = 1'b0;
        checkOutput("idle_after_done",
                    136'({bus.busy, bus.done, bus.pad_output_input, bus.pad_enable, bus.pad_data_in}),
                    136'(5'b00001));
        checkOutput("resp_hold", bus.resp_data, er);
    endtask

    initial begin
        bus.cmd_start    = 1'b0;
        bus.cmd_index    = '0;
        bus.cmd_arg      = '0;
        bus.resp_type    = '0;
        bus.pad_data_out = 1'b1;
        repeat (3) @(negedge sd_clock);
        checkOutput("reset_outputs",
                    136'({bus.busy, bus.done, bus.pad_output_input, bus.pad_enable,
                          bus.pad_data_in, bus.timeout_err, bus.crc_err}),
                    136'(7'b0000100));
        checkOutput("reset_resp", bus.resp_data, '0);
        reset_n = 1'b1;
        @(negedge sd_clock);

        $display("[TB] CMD0, no response, start held during DONE");
        applyStimulus(6'd0, 32'h0, 2'b00, -1);
        checkOutput("cmd0_frame_const", 136'(sent_frame), 136'(48'h400000000095));
        bus.cmd_start = 1'b1;
        checkDone('0, 1'b0, 1'b0);

        $display("[TB] CMD8 with valid short response");
        applyStimulus(6'd8, 32'h000001AA, 2'b01, -1);
        checkOutput("cmd8_frame_const", 136'(sent_frame), 136'(48'h48000001AA87));
        driveResponse(136'h08000001AA13, 48, 5);
        checkDone(136'h08000001AA13, 1'b0, 1'b0);

        $display("[TB] CMD8 with no card response");
        applyStimulus(6'd8, 32'h000001AA, 2'b01, -1);
        bus.pad_data_out = 1'b1;
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 500) begin
            @(negedge sd_clock);
            cnt++;
        end
        checkOutput("timeout_latency", 136'(cnt), 136'(TURN_CYC + TIMEOUT));
        checkDone('0, 1'b1, 1'b0);

        $display("[TB] CMD8 with corrupted response CRC");
        applyStimulus(6'd8, 32'h000001AA, 2'b01, -1);
        driveResponse(136'h08000001AA15, 48, 3);
        checkDone(136'h08000001AA15, 1'b0, exp_crc_err(136'h08000001AA15, 2'b01));

        $display("[TB] long response");
        resp = {2'b00, 6'h3F, 120'h035344534430384780123456780139, 7'b0, 1'b1};
        resp[7:1] = crc_div({8'b0, resp[127:8]}, 120);
        applyStimulus(6'd2, 32'h0, 2'b10, -1);
        driveResponse(resp, 136, 0);
        checkDone(resp, 1'b0, 1'b0);

        $display("[TB] reset in IDLE clears held response");
        reset_n = 1'b0;
        #1;
        checkOutput("idle_reset_resp", bus.resp_data, '0);
        @(negedge sd_clock);
        reset_n = 1'b1;
        @(negedge sd_clock);

        $display("[TB] reset during SEND bit 20, then restart with start poked during SEND");
        idx = 6'(17);
        arg = 32'hDEADBEEF;
        exp_frame = cmd_frame(idx, arg);
        bus.cmd_index = idx;
        bus.cmd_arg   = arg;
        bus.resp_type = 2'b01;
        bus.cmd_start = 1'b1;
        @(negedge sd_clock);
        bus.cmd_start = 1'b0;
        repeat (27) @(negedge sd_clock);
        checkOutput("bit20_on_line", 136'(bus.pad_data_in), 136'(exp_frame[20]));
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abort_outputs",
                    136'({bus.busy, bus.done, bus.pad_output_input, bus.pad_enable,
                          bus.pad_data_in, bus.timeout_err, bus.crc_err}),
                    136'(7'b0000100));
        @(negedge sd_clock);
        reset_n = 1'b1;
        @(negedge sd_clock);
        checkOutput("no_done_after_abort", 136'({bus.busy, bus.done}), 136'(0));
        applyStimulus(6'h3A, 32'h12345678, 2'b00, 10);
        checkDone('0, 1'b0, 1'b0);

        $display("[TB] randomized commands");
        for (int k = 0; k < 8; k++) begin
            idx = 6'($urandom);
            arg = $urandom;
            rt  = (k == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            gap = $urandom_range(0, 20);
            rnd = {$urandom, $urandom, $urandom, $urandom};
            resp = '0;
            if (rt == 2'b01) begin
                resp[47:0] = {2'b00, rnd[37:32], rnd[31:0], 7'b0, 1'b1};
                resp[7:1]  = crc_div({88'b0, resp[47:8]}, 40);
            end else if (rt == 2'b10) begin
                resp = {2'b00, 6'h3F, rnd[119:0], 7'b0, 1'b1};
                resp[7:1] = crc_div({8'b0, resp[127:8]}, 120);
            end
            if ($urandom_range(0, 1) == 1) resp[7:1] = resp[7:1] ^ 7'($urandom_range(1, 127));
            applyStimulus(idx, arg, rt, -1);
            if (rt == 2'b01 || rt == 2'b10) begin
                driveResponse(resp, (rt == 2'b10) ? 136 : 48, gap);
                checkDone(resp, 1'b0, exp_crc_err(resp, rt));
            end else begin
                checkDone('0, 1'b0, 1'b0);
            end
            repeat ($urandom_range(0, 2)) @(negedge sd_clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/sd_cmd_ctrl.md
Name: sd_cmd_ctrl

Overview:
Sequencer for the SD host CMD-line pad.
- Builds a 48-bit command frame from index and argument, generates its CRC7, and serialises the frame MSB-first through the pad.
- Releases the line, waits for the card's response start bit within a bounded window, then deserialises a 48-bit or 136-bit response.
- Sits between the host command logic and the pad instance; owns the pad's direction, enable and data-in signals exclusively.

Parameters:
- TIMEOUT, 64, max sd_clock cycles in WAIT_START before the response is declared absent (NCR limit).
- TURN_CYC, 2, cycles the line stays released after the end bit before start-bit search begins.

Ports:
- sd_clock  input  1  SD bus clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cmd_start  input  1  1-cycle request; sampled only in IDLE.
- cmd_index  input  6  command index.
- cmd_arg  input  32  command argument.
- resp_type  input  2  00 none, 01 48-bit, 10 136-bit, 11 treated as 00.
- pad_output_input  output  1  1 = pad drives CMD, 0 = pad receives.
- pad_enable  output  1  pad enable; 1 whenever busy.
- pad_data_in  output  1  bit driven onto CMD.
- pad_data_out  input  1  bit sampled from CMD.
- busy  output  1  high from the cycle after an accepted cmd_start until DONE exits.
- done  output  1  1-cycle pulse at completion.
- resp_data  output  136  received frame, right-justified (48-bit response in [47:0], upper bits 0); holds until the next cmd_start is accepted.
- timeout_err  output  1  valid with done; held until the next accepted cmd_start.
- crc_err  output  1  valid with done; see Optional Feature.

Behaviour:
- Reset values, asynchronous, any state: state=IDLE, pad_output_input=0, pad_enable=0, pad_data_in=1, busy=0, done=0, resp_data=0, timeout_err=0, crc_err=0.
- Reset mid-frame aborts immediately; no done pulse is generated.
- Frame layout: start 0, transmission 1, index[5:0], arg[31:0], CRC7[6:0], end 1.
- CRC7: polynomial x^7+x^3+1, initial 0, computed over the first 40 bits in serial while shifting.
- IDLE: on cmd_start=1, latch index, arg and resp_type; clear errors and resp_data; go to SEND. cmd_start in any other state is ignored.
- SEND: pad_output_input=1 and pad_enable=1 for exactly 48 cycles.
  - Frame bit 47 (start bit) is on pad_data_in in the first cycle after the accepting edge.
  - A 6-bit bit counter runs 47 down to 0.
  - After bit 0, go to DONE if resp_type is none, else TURN.
- TURN: pad_output_input=0, pad_data_in=1, for TURN_CYC cycles; then WAIT_START.
- WAIT_START: sample pad_data_out each cycle.
  - On 0: record it as frame MSB and go to RECV.
  - After TIMEOUT cycles with no 0: set timeout_err=1 and go to DONE.
  - The TIMEOUT counter saturates; it does not wrap.
- RECV: shift pad_data_out into resp_data LSB-first-in (left shift) for 47 more bits (short) or 135 more bits (long); then DONE.
  - End-bit value is captured but not checked.
- DONE: done=1 and busy=1 for one cycle; return to IDLE.
  - A cmd_start in the DONE cycle is ignored; the earliest accepted start is the following cycle.
- Pad released (pad_output_input=0) in every state except SEND.

Optional Feature:
- Macro: SD_CMD_RESP_CRC_CHECK_EN.
- When defined: for 48-bit responses, CRC7 is computed over received bits 47..8 and compared with bits 7..1; a mismatch sets crc_err at done. For 136-bit responses, CRC7 is computed over bits 127..8 (the CID/CSD field) and compared with bits 7..1.
- When undefined: no checker logic exists and crc_err is tied to 0.
- Timeout responses never set crc_err.

Test Plan:
- Reset, then cmd_start with index 0, arg 0x00000000, resp_type 00 -> pad_data_in serialises 0x400000000095 over 48 cycles; done on cycle 49; busy low afterwards; pad released.
- Index 8, arg 0x000001AA, resp_type 01; bench drives 0x08000001AA13 after 5 idle cycles -> frame 0x48000001AA87 sent; resp_data[47:0]=0x08000001AA13, upper bits 0; timeout_err=0; crc_err=0.
- Same command, but the bench holds CMD high -> done exactly TIMEOUT+TURN_CYC cycles after the end bit; timeout_err=1; resp_data=0.
- With SD_CMD_RESP_CRC_CHECK_EN, response 0x08000001AA15 (CRC corrupted) -> crc_err=1 at done; without the macro, crc_err=0.
- 136-bit response (resp_type 10) with a known frame -> all 136 bits land in resp_data; done one cycle after the last bit.
- reset_n pulsed low at bit 20 of SEND -> outputs return to reset values the same cycle; a new cmd_start after release sends a full correct frame; a cmd_start during SEND is ignored with no frame restart.
